// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
// Shares one APB master between NUM_REQ requesters with round-robin
// arbitration. Drives the master's bridge-side inputs (trans/addr/wdata/
// wr_rd) from the granted requester and snoops the APB bus to detect
// transfer completion, then returns a one-cycle ack with read data/error.
//
// Optional feature macro: APB_ARB_LOCK_EN (adds lock_i; lets the acked
// requester keep the grant for one extra IDLE cycle to re-request).
//
// Ports:
//   pclk, preset        clock, synchronous active-high reset
//   req_i   [NUM_REQ]   per-requester request level
//   addr_i  / wdata_i   flattened per-requester address / write data
//   wr_rd_i [NUM_REQ]   1=write, 0=read
//   lock_i  [NUM_REQ]   (APB_ARB_LOCK_EN only) keep grant after ack
//   ack_o   [NUM_REQ]   one-cycle completion pulse
//   rdata_o / err_o     captured prdata / pslverr, valid with ack_o
//   gnt_o   [NUM_REQ]   one-hot current grant
//   trans_o, addr_o, wdata_o, wr_rd_o   requests into the APB master
//   pselx, penable, pready, pslverr, prdata   snooped APB bus
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
    input  logic [NUM_REQ-1:0]               wr_rd_i,
`ifdef APB_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]               lock_i,
`endif
    output logic [NUM_REQ-1:0]               ack_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             err_o,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic                             trans_o,
    output logic [ADDR_WIDTH-1:0]            addr_o,
    output logic [DATA_WIDTH-1:0]            wdata_o,
    output logic                             wr_rd_o,
    input  logic                             pselx,
    input  logic                             penable,
    input  logic                             pready,
    input  logic                             pslverr,
    input  logic [DATA_WIDTH-1:0]            prdata
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [IDX_W-1:0]      r_rr_ptr;

    logic [1:0]            w_state_nxt;
    logic [NUM_REQ-1:0]    w_gnt_nxt;
    logic [NUM_REQ-1:0]    w_ack_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic                  w_err_nxt;
    logic [IDX_W-1:0]      w_rr_nxt;

    logic                  w_complete;
    logic [IDX_W-1:0]      w_cur_idx;
    logic [NUM_REQ-1:0]    w_arb_req;
    logic [IDX_W-1:0]      w_arb_ptr;
    logic                  w_arb_found;
    logic [NUM_REQ-1:0]    w_arb_gnt;

`ifdef APB_ARB_LOCK_EN
    logic                  r_lock;
    logic                  w_lock_nxt;
`endif

    assign w_complete = pselx & penable & pready;

    // Index of the currently granted requester (grant is one-hot)
    always_comb begin
        w_cur_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (r_gnt[k]) w_cur_idx = IDX_W'(k);
        end
    end

    // In DONE the acked requester still holds req_i, so mask it and search
    // from its index (which becomes the new rr pointer this cycle)
    assign w_arb_req = (r_state == S_DONE) ? (req_i & ~r_gnt) : req_i;
    assign w_arb_ptr = (r_state == S_DONE) ? w_cur_idx : r_rr_ptr;

    // Round-robin search: first set request starting at ptr+1 (wrapping)
    always_comb begin
        int unsigned v_idx;
        w_arb_found = 1'b0;
        w_arb_gnt   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            v_idx = 32'(w_arb_ptr) + i;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            if (!w_arb_found && w_arb_req[IDX_W'(v_idx)]) begin
                w_arb_found                = 1'b1;
                w_arb_gnt[IDX_W'(v_idx)]   = 1'b1;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = '0;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_rr_nxt    = r_rr_ptr;
`ifdef APB_ARB_LOCK_EN
        w_lock_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef APB_ARB_LOCK_EN
                // Locked cycle: only the previous owner may re-request
                if (r_lock) begin
                    if (|(req_i & r_gnt)) w_state_nxt = S_BUSY;
                    else                  w_gnt_nxt   = '0;
                end else
`endif
                if (w_arb_found) begin
                    w_gnt_nxt   = w_arb_gnt;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_complete) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = r_gnt;
                    w_err_nxt   = pslverr;
                    if (!wr_rd_o) w_rdata_nxt = prdata;
                end
            end
            S_DONE: begin
                w_rr_nxt = w_cur_idx;
`ifdef APB_ARB_LOCK_EN
                if (lock_i[w_cur_idx]) begin
                    w_lock_nxt  = 1'b1;
                    w_rr_nxt    = r_rr_ptr;
                    w_state_nxt = S_IDLE;
                end else
`endif
                if (w_arb_found) begin
                    w_gnt_nxt   = w_arb_gnt;
                    w_state_nxt = S_BUSY;
                end else begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rr_ptr <= IDX_W'(NUM_REQ - 1);
`ifdef APB_ARB_LOCK_EN
            r_lock   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ack    <= w_ack_nxt;
            r_rdata  <= w_rdata_nxt;
            r_err    <= w_err_nxt;
            r_rr_ptr <= w_rr_nxt;
`ifdef APB_ARB_LOCK_EN
            r_lock   <= w_lock_nxt;
`endif
        end
    end

    // One-hot OR mux of the granted requester's payload (zero with no grant)
    always_comb begin
        addr_o  = '0;
        wdata_o = '0;
        wr_rd_o = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (r_gnt[k]) begin
                addr_o  = addr_o  | addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_o = wdata_o | wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                wr_rd_o = wr_rd_o | wr_rd_i[k];
            end
        end
    end

    // Drop trans in the completion cycle so the master returns to IDLE
    assign trans_o = (r_state == S_BUSY) & ~w_complete;

    assign gnt_o   = r_gnt;
    assign ack_o   = r_ack;
    assign rdata_o = r_rdata;
    assign err_o   = r_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
// Directed bench for apb_req_arbiter with a small APB master + slave model.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic               pclk = 1'b0;
    logic               preset;
    logic [NR-1:0]      req_i;
    logic [NR*AW-1:0]   addr_i;
    logic [NR*DW-1:0]   wdata_i;
    logic [NR-1:0]      wr_rd_i;
`ifdef APB_ARB_LOCK_EN
    logic [NR-1:0]      lock_i;
`endif
    logic [NR-1:0]      ack_o;
    logic [DW-1:0]      rdata_o;
    logic               err_o;
    logic [NR-1:0]      gnt_o;
    logic               trans_o;
    logic [AW-1:0]      addr_o;
    logic [DW-1:0]      wdata_o;
    logic               wr_rd_o;
    logic               pselx, penable, pready, pslverr;
    logic [DW-1:0]      prdata;

    int n_checks = 0;
    int n_errors = 0;

    // Slave behaviour knobs
    int          wait_states;
    logic [DW-1:0] slv_rdata;
    logic        slv_err;

    always #5 pclk = ~pclk;

    apb_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .req_i   (req_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .wr_rd_i (wr_rd_i),
`ifdef APB_ARB_LOCK_EN
        .lock_i  (lock_i),
`endif
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .gnt_o   (gnt_o),
        .trans_o (trans_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .wr_rd_o (wr_rd_o),
        .pselx   (pselx),
        .penable (penable),
        .pready  (pready),
        .pslverr (pslverr),
        .prdata  (prdata)
    );

    // APB master model: IDLE(0) -> SETUP(1) -> ACCESS(2)
    logic [1:0] m_st;
    int         m_cnt;

    always @(posedge pclk) begin
        if (preset) begin
            m_st  <= 2'd0;
            m_cnt <= 0;
        end else begin
            case (m_st)
                2'd0: if (trans_o) m_st <= 2'd1;
                2'd1: begin m_st <= 2'd2; m_cnt <= 0; end
                2'd2: begin
                    if (pready) m_st <= trans_o ? 2'd1 : 2'd0;
                    else        m_cnt <= m_cnt + 1;
                end
                default: m_st <= 2'd0;
            endcase
        end
    end

    assign pselx   = (m_st != 2'd0);
    assign penable = (m_st == 2'd2);
    assign pready  = (m_st == 2'd2) && (m_cnt >= wait_states);
    assign pslverr = slv_err;
    assign prdata  = slv_rdata;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [NR-1:0] exp_g;
        preset      = 1'b1;
        req_i       = '0;
        addr_i      = '0;
        wdata_i     = '0;
        wr_rd_i     = '0;
`ifdef APB_ARB_LOCK_EN
        lock_i      = '0;
`endif
        wait_states = 0;
        slv_rdata   = '0;
        slv_err     = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_gnt",   64'(gnt_o),   64'h0);
        chk("rst_ack",   64'(ack_o),   64'h0);
        chk("rst_rdata", 64'(rdata_o), 64'h0);
        chk("rst_err",   64'(err_o),   64'h0);
        chk("rst_trans", 64'(trans_o), 64'h0);
        chk("rst_addr",  64'(addr_o),  64'h0);
        preset = 1'b0;

        // All four requesters at once: grants 0,1,2,3 with a DONE between
        for (int k = 0; k < 4; k++) addr_i[k*AW +: AW] = 32'h0000_0100 + 32'(k) * 32'h10;
        req_i = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_g     = 4'(1 << k);
            slv_rdata = 32'hA000_0000 + 32'(k);
            tick();
            chk("all_gnt",   64'(gnt_o),   64'(exp_g));
            chk("all_addr",  64'(addr_o),  64'(32'h0000_0100 + 32'(k) * 32'h10));
            chk("all_trans", 64'(trans_o), 64'h1);
            chk("all_ack0",  64'(ack_o),   64'h0);
            tick(); tick();
            chk("all_trans_drop", 64'(trans_o), 64'h0);
            tick();
            chk("all_ack",   64'(ack_o),   64'(exp_g));
            chk("all_rdata", 64'(rdata_o), 64'(32'hA000_0000 + 32'(k)));
            req_i[k] = 1'b0;
        end
        tick();
        chk("all_idle_gnt", 64'(gnt_o), 64'h0);
        chk("all_idle_ack", 64'(ack_o), 64'h0);

        // Single read by requester 0
        addr_i[0*AW +: AW] = 32'h0000_0010;
        slv_rdata = 32'hDEAD_BEEF;
        req_i = 4'b0001;
        tick();
        chk("rd_gnt",   64'(gnt_o),  64'h1);
        chk("rd_addr",  64'(addr_o), 64'h10);
        chk("rd_wr_rd", 64'(wr_rd_o), 64'h0);
        tick(); tick();
        tick();
        chk("rd_ack",   64'(ack_o),   64'h1);
        chk("rd_rdata", 64'(rdata_o), 64'hDEAD_BEEF);
        chk("rd_err",   64'(err_o),   64'h0);
        req_i = '0;
        tick();
        chk("rd_ack_once", 64'(ack_o), 64'h0);
        chk("rd_gnt_clr",  64'(gnt_o), 64'h0);

        // Write by requester 1 with three wait states
        addr_i[1*AW +: AW]  = 32'h0000_0040;
        wdata_i[1*DW +: DW] = 32'h1234_5678;
        wr_rd_i[1] = 1'b1;
        wait_states = 3;
        slv_rdata   = 32'h5555_5555;
        req_i = 4'b0010;
        tick();
        chk("wr_gnt",   64'(gnt_o),   64'h2);
        chk("wr_wr_rd", 64'(wr_rd_o), 64'h1);
        chk("wr_wdata", 64'(wdata_o), 64'h1234_5678);
        tick();
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("wr_wait_trans", 64'(trans_o), 64'h1);
            chk("wr_wait_wdata", 64'(wdata_o), 64'h1234_5678);
            chk("wr_wait_ack",   64'(ack_o),   64'h0);
        end
        tick();
        chk("wr_trans_drop", 64'(trans_o), 64'h0);
        tick();
        chk("wr_ack",   64'(ack_o),   64'h2);
        chk("wr_err",   64'(err_o),   64'h0);
        chk("wr_rdata_kept", 64'(rdata_o), 64'hDEAD_BEEF);
        req_i = '0;
        wr_rd_i[1] = 1'b0;
        wait_states = 0;
        tick();
        chk("wr_gnt_clr", 64'(gnt_o), 64'h0);

        // Reset while requester 2 is BUSY; afterwards requester 0 beats 2
        addr_i[2*AW +: AW] = 32'h0000_0200;
        req_i = 4'b0100;
        tick();
        chk("rb_gnt", 64'(gnt_o), 64'h4);
        tick();
        preset = 1'b1;
        tick();
        chk("rb_gnt0",   64'(gnt_o),   64'h0);
        chk("rb_ack0",   64'(ack_o),   64'h0);
        chk("rb_rdata0", 64'(rdata_o), 64'h0);
        chk("rb_err0",   64'(err_o),   64'h0);
        chk("rb_trans0", 64'(trans_o), 64'h0);
        preset = 1'b0;
        req_i = 4'b0101;
        slv_rdata = 32'h0BAD_F00D;
        tick();
        chk("rb_rr_gnt", 64'(gnt_o), 64'h1);
        chk("rb_noack",  64'(ack_o), 64'h0);
        tick(); tick(); tick();
        chk("rb_ack",   64'(ack_o),   64'h1);
        chk("rb_rdata", 64'(rdata_o), 64'h0BAD_F00D);
        req_i = '0;
        tick();
        chk("rb_gnt_clr", 64'(gnt_o), 64'h0);

        // Slave error on a read by requester 3
        slv_err   = 1'b1;
        slv_rdata = 32'hBAD0_BAD0;
        req_i = 4'b1000;
        tick();
        chk("er_gnt", 64'(gnt_o), 64'h8);
        tick(); tick(); tick();
        chk("er_ack",   64'(ack_o),   64'h8);
        chk("er_err",   64'(err_o),   64'h1);
        chk("er_rdata", 64'(rdata_o), 64'hBAD0_BAD0);
        req_i = '0;
        slv_err = 1'b0;
        tick();
        chk("er_gnt_clr", 64'(gnt_o), 64'h0);

        // Fairness: requesters 1 and 2 held high -> grants alternate 1,2,1,2
        slv_rdata = 32'h0000_00F0;
        req_i = 4'b0110;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 4'b0010 : 4'b0100;
            tick();
            chk("fair_gnt", 64'(gnt_o), 64'(exp_g));
            tick(); tick(); tick();
            chk("fair_ack", 64'(ack_o), 64'(exp_g));
            chk("fair_err", 64'(err_o), 64'h0);
        end
        req_i = '0;
        tick();
        chk("fair_gnt_clr", 64'(gnt_o), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
